move_validator: RTL

- Datapath stage directly downstream of the game FSM's check-valid-move enable, and upstream of the place/flip stage.
- On a start pulse, scans the 8x8 board outward from the cursor in all 8 directions. It decides whether the current player's move is legal and builds the mask of opponent pieces to flip.
- Returns a one-cycle done pulse, used as the FSM's `go`, plus a held `valid_move` level.

---
 rtl/reversi_pkg.sv | 28 ++
 rtl/board_step.sv | 27 ++
 rtl/move_validator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reversi_pkg.sv
// Shared Reversi definitions: cell encodings, direction tables, FSM state codes
// and the board address helper used by the move validator.
package reversi_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  // Direction order: N, NE, E, SE, S, SW, W, NW (y grows downward).
  localparam logic signed [3:0] DIR_DX [8] = '{4'sd0, 4'sd1, 4'sd1, 4'sd1,
                                               4'sd0, -4'sd1, -4'sd1, -4'sd1};
  localparam logic signed [3:0] DIR_DY [8] = '{-4'sd1, -4'sd1, 4'sd0, 4'sd1,
                                               4'sd1, 4'sd1, 4'sd0, -4'sd1};

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_ORIGIN_WAIT = 3'd1;
  localparam state_t ST_STEP        = 3'd2;
  localparam state_t ST_READ_WAIT   = 3'd3;
  localparam state_t ST_NEXT_DIR    = 3'd4;
  localparam state_t ST_FINISH      = 3'd5;

  function automatic logic [5:0] board_addr(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/board_step.sv
// One step from (x, y) along direction dir; a coordinate leaving 0..7 sets
// bit 3 of its 4-bit signed sum, which flags out_of_bounds (no row wrap).
module board_step
  import reversi_pkg::*;
(
  input  logic [2:0] x_i,
  input  logic [2:0] y_i,
  input  logic [2:0] dir_i,
  output logic [2:0] next_x_o,
  output logic [2:0] next_y_o,
  output logic [5:0] next_addr_o,
  output logic       out_of_bounds_o
);

  logic signed [3:0] sx;
  logic signed [3:0] sy;

  always_comb begin
    sx              = $signed({1'b0, x_i}) + DIR_DX[dir_i];
    sy              = $signed({1'b0, y_i}) + DIR_DY[dir_i];
    next_x_o        = sx[2:0];
    next_y_o        = sy[2:0];
    next_addr_o     = board_addr(sx[2:0], sy[2:0]);
    out_of_bounds_o = sx[3] | sy[3];
  end

endmodule

// File: rtl/move_validator.sv
// Reversi move legality scan: walks all 8 directions from the cursor and builds
// the flip mask. Define MOVE_VALIDATOR_EARLY_EXIT_EN to stop at the first legal direction.
//
// Handshake: start is a one-cycle request, accepted only in IDLE (dropped while
// busy). done pulses for one cycle as busy falls; valid_move and flip_mask are
// then held until the next accepted start.
module move_validator
  import reversi_pkg::*;
#(
  parameter int BOARD_DIM = 8,
  parameter int ADDR_W    = 6
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [2:0]                     cursor_x,
  input  logic [2:0]                     cursor_y,
  input  logic                           player,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic [1:0]                     rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           valid_move,
  output logic [BOARD_DIM*BOARD_DIM-1:0] flip_mask,
  output logic [2:0]                     dbg_state
);

  localparam int CELLS = BOARD_DIM * BOARD_DIM;

  state_t             state_q, state_d;
  logic [2:0]         dir_q, dir_d;
  logic [2:0]         run_q, run_d;
  logic [2:0]         org_x_q, org_x_d, org_y_q, org_y_d;
  logic [2:0]         cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic               player_q, player_d;
  logic [CELLS-1:0]   dir_mask_q, dir_mask_d;
  logic [CELLS-1:0]   flip_q, flip_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;

  logic [2:0]         nx, ny;
  logic [5:0]         naddr;
  logic               oob;
  logic [1:0]         own_c, opp_c;

  board_step u_step (
    .x_i             (cur_x_q),
    .y_i             (cur_y_q),
    .dir_i           (dir_q),
    .next_x_o        (nx),
    .next_y_o        (ny),
    .next_addr_o     (naddr),
    .out_of_bounds_o (oob)
  );

  assign own_c = player_q ? CELL_WHITE : CELL_BLACK;
  assign opp_c = player_q ? CELL_BLACK : CELL_WHITE;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    run_d      = run_q;
    org_x_d    = org_x_q;
    org_y_d    = org_y_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    player_d   = player_q;
    dir_mask_d = dir_mask_q;
    flip_d     = flip_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_addr_d  = rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          org_x_d    = cursor_x;
          org_y_d    = cursor_y;
          cur_x_d    = cursor_x;
          cur_y_d    = cursor_y;
          player_d   = player;
          rd_addr_d  = board_addr(cursor_x, cursor_y);
          valid_d    = 1'b0;
          flip_d     = '0;
          dir_mask_d = '0;
          run_d      = 3'd0;
          busy_d     = 1'b1;
          state_d    = ST_ORIGIN_WAIT;
        end
      end
      ST_ORIGIN_WAIT: begin
        // Reserved code 11 counts as empty, so only real pieces block the move.
        if (rd_data == CELL_BLACK || rd_data == CELL_WHITE) begin
          state_d = ST_FINISH;
        end else begin
          dir_d   = 3'd0;
          run_d   = 3'd0;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (oob) begin
          state_d = ST_NEXT_DIR;
        end else begin
          rd_addr_d = naddr;
          cur_x_d   = nx;
          cur_y_d   = ny;
          state_d   = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (rd_data == opp_c) begin
          dir_mask_d = dir_mask_q | (CELLS'(1) << rd_addr_q);
          run_d      = run_q + 3'd1;
          state_d    = ST_STEP;
        end else if (rd_data == own_c && run_q != 3'd0) begin
          valid_d = 1'b1;
          flip_d  = flip_q | dir_mask_q;
`ifdef MOVE_VALIDATOR_EARLY_EXIT_EN
          state_d = ST_FINISH;
`else
          state_d = ST_NEXT_DIR;
`endif
        end else begin
          state_d = ST_NEXT_DIR;
        end
      end
      ST_NEXT_DIR: begin
        dir_mask_d = '0;
        run_d      = 3'd0;
        cur_x_d    = org_x_q;
        cur_y_d    = org_y_q;
        dir_d      = dir_q + 3'd1;
        state_d    = (dir_q == 3'd7) ? ST_FINISH : ST_STEP;
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      dir_q      <= 3'd0;
      run_q      <= 3'd0;
      org_x_q    <= 3'd0;
      org_y_q    <= 3'd0;
      cur_x_q    <= 3'd0;
      cur_y_q    <= 3'd0;
      player_q   <= 1'b0;
      dir_mask_q <= '0;
      flip_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      run_q      <= run_d;
      org_x_q    <= org_x_d;
      org_y_q    <= org_y_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      player_q   <= player_d;
      dir_mask_q <= dir_mask_d;
      flip_q     <= flip_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign valid_move = valid_q;
  assign flip_mask  = flip_q;
  assign dbg_state  = state_q;

endmodule
